// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the BeeF core: gates PC updates, stalls after POP and
// scans for matching brackets on taken CBF/CBB, squashing datapath writes meanwhile.
module core_sequencer #(
  parameter  int DEPTH_W = 8,
  parameter  int POP_LAT = 1,
  localparam int STALL_W = $clog2(POP_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         instruction,
  input  logic               instr_valid,
  input  logic               acc_zero,
  output logic               pc_write,
  output logic               pc_dir,
  output logic               squash,
  output logic [2:0]         state,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow
);

  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_DEC = 3'd1;
  localparam logic [2:0] OP_PSH = 3'd2;
  localparam logic [2:0] OP_POP = 3'd3;
  localparam logic [2:0] OP_MVR = 3'd4;
  localparam logic [2:0] OP_MVL = 3'd5;
  localparam logic [2:0] OP_CBF = 3'd6;
  localparam logic [2:0] OP_CBB = 3'd7;

  localparam logic [2:0] ST_CORE   = 3'd0;
  localparam logic [2:0] ST_STALL  = 3'd1;
  localparam logic [2:0] ST_SCAN_F = 3'd2;
  localparam logic [2:0] ST_SCAN_B = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_LD  = STALL_W'(POP_LAT);

  logic [2:0]         state_d;
  logic [DEPTH_W-1:0] depth_d;
  logic [STALL_W-1:0] stall_cnt, stall_d;
  logic               overflow_d;
  logic               dec_at_zero;
  logic               open_br, close_br;

  // In a scan the "opening" bracket is the one that deepens nesting: CBF going
  // forward, CBB going backward.
  always_comb begin
    open_br  = 1'b0;
    close_br = 1'b0;
    if (state == ST_SCAN_F) begin
      open_br  = (instruction == OP_CBF);
      close_br = (instruction == OP_CBB);
    end else if (state == ST_SCAN_B) begin
      open_br  = (instruction == OP_CBB);
      close_br = (instruction == OP_CBF);
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // latch behind.
  always_comb begin
    state_d     = state;
    depth_d     = depth;
    stall_d     = stall_cnt;
    overflow_d  = overflow;
    pc_write    = 1'b0;
    pc_dir      = 1'b0;
    squash      = 1'b1;
    dec_at_zero = 1'b0;

    case (state)
      ST_CORE: begin
        squash = 1'b0;
        if (instr_valid) begin
          if (instruction == OP_POP) begin
            stall_d = STALL_LD;
            state_d = ST_STALL;
          end else if (instruction == OP_CBF && acc_zero) begin
            pc_write = 1'b1;
            depth_d  = DEPTH_ONE;
            state_d  = ST_SCAN_F;
          end else if (instruction == OP_CBB && !acc_zero) begin
            pc_write = 1'b1;
            pc_dir   = 1'b1;
            depth_d  = DEPTH_ONE;
            state_d  = ST_SCAN_B;
          end else begin
            pc_write = 1'b1;
          end
        end
      end

      ST_STALL: begin
        if (stall_cnt > STALL_ONE) begin
          stall_d = stall_cnt - STALL_ONE;
        end else begin
          pc_write = 1'b1;
          stall_d  = '0;
          state_d  = ST_CORE;
        end
      end

      ST_SCAN_F, ST_SCAN_B: begin
        pc_dir = (state == ST_SCAN_B);
        if (instr_valid) begin
          pc_write = 1'b1;
          if (open_br) begin
            if (depth == DEPTH_MAX) begin
              overflow_d = 1'b1;
              state_d    = ST_HALT;
            end else begin
              depth_d = depth + DEPTH_ONE;
            end
          end else if (close_br) begin
            dec_at_zero = (depth == '0);
            if (depth != '0) depth_d = depth - DEPTH_ONE;
            if (depth == DEPTH_ONE) begin
              // Matching bracket found: the PC steps past it in the forward direction.
              pc_dir  = 1'b0;
              state_d = ST_CORE;
            end
          end
        end
      end

      ST_HALT: ;

      default: state_d = ST_CORE;
    endcase

    if (!rst_n) begin
      pc_write = 1'b0;
      pc_dir   = 1'b0;
      squash   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_CORE;
      depth     <= '0;
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      depth     <= depth_d;
      stall_cnt <= stall_d;
      overflow  <= overflow_d;
    end
  end

  a_no_dec_at_zero: assert property (@(posedge clk) disable iff (!rst_n) !dec_at_zero);

  // The remaining opcodes behave identically here; named for readability only.
  logic unused_ops;
  assign unused_ops = ^{OP_INC, OP_DEC, OP_PSH, OP_MVR, OP_MVL};

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer (DEPTH_W=2, POP_LAT=3): each driven cycle
// queues its expected Mealy outputs and post-edge registers for the monitor.
module tb_core_sequencer;

  localparam logic [2:0] INC = 3'd0, DEC = 3'd1, PSH = 3'd2, POP = 3'd3;
  localparam logic [2:0] MVR = 3'd4, MVL = 3'd5, CBF = 3'd6, CBB = 3'd7;
  localparam logic [2:0] S_CORE = 3'd0, S_STALL = 3'd1, S_SCAN_F = 3'd2;
  localparam logic [2:0] S_SCAN_B = 3'd3, S_HALT = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] instruction = INC;
  logic       instr_valid = 1'b0;
  logic       acc_zero = 1'b0;
  logic       pc_write, pc_dir, squash, overflow;
  logic [2:0] state;
  logic [1:0] depth;

  core_sequencer #(.DEPTH_W(2), .POP_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .acc_zero(acc_zero), .pc_write(pc_write), .pc_dir(pc_dir), .squash(squash),
    .state(state), .depth(depth), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       pw;
    logic       dir;
    logic       sq;
    logic       chk_pw;
    logic [2:0] st;
    logic [1:0] dp;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge and queues what it must produce.
  task automatic drive(input string tag, input logic rst, input logic v, input logic [2:0] op,
                       input logic az, input logic pw, input logic dir, input logic sq,
                       input logic chk_pw, input logic [2:0] st, input logic [1:0] dp,
                       input logic ovf);
    exp_t e;
    @(negedge clk);
    rst_n = rst; instr_valid = v; instruction = op; acc_zero = az;
    e.tag = tag; e.pw = pw; e.dir = dir; e.sq = sq; e.chk_pw = chk_pw;
    e.st = st; e.dp = dp; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: Mealy outputs just before the edge, registers just after it.
  initial begin
    logic s_pw, s_dir, s_sq;
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      s_pw = pc_write; s_dir = pc_dir; s_sq = squash;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_pw) check({e.tag, ".pc_write"}, 32'(s_pw), 32'(e.pw));
        check({e.tag, ".pc_dir"},   32'(s_dir),    32'(e.dir));
        check({e.tag, ".squash"},   32'(s_sq),     32'(e.sq));
        check({e.tag, ".state"},    32'(state),    32'(e.st));
        check({e.tag, ".depth"},    32'(depth),    32'(e.dp));
        check({e.tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] plain_ops [5];
    plain_ops[0] = INC; plain_ops[1] = DEC; plain_ops[2] = PSH;
    plain_ops[3] = MVR; plain_ops[4] = MVL;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      drive("rst", 1'b0, 1'($urandom), 3'($urandom), 1'($urandom),
            1'b0, 1'b0, 1'b1, 1'b1, S_CORE, 2'd0, 1'b0);
    drive("idle", 1'b1, 1'b0, POP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_CORE, 2'd0, 1'b0);

    // POP stall: pc_write 0,0,0,1
    drive("pop",    1'b1, 1'b1, POP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_STALL, 2'd0, 1'b0);
    drive("stall1", 1'b1, 1'b1, CBF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_STALL, 2'd0, 1'b0);
    drive("stall2", 1'b1, 1'b0, INC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_STALL, 2'd0, 1'b0);
    drive("stall3", 1'b1, 1'b1, POP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_CORE,  2'd0, 1'b0);

    // Plain opcodes and not-taken branches take one cycle each
    for (int i = 0; i < 8; i++)
      drive("plain", 1'b1, 1'b1, plain_ops[$urandom_range(4, 0)], 1'($urandom),
            1'b1, 1'b0, 1'b0, 1'b1, S_CORE, 2'd0, 1'b0);
    drive("cbf_nt", 1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_CORE, 2'd0, 1'b0);
    drive("cbb_nt", 1'b1, 1'b1, CBB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, S_CORE, 2'd0, 1'b0);

    // Forward scan: CBF taken, then CBF INC CBB CBB
    drive("fs_cbf0", 1'b1, 1'b1, CBF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, S_SCAN_F, 2'd1, 1'b0);
    drive("fs_cbf",  1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_SCAN_F, 2'd2, 1'b0);
    drive("fs_inc",  1'b1, 1'b1, INC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_SCAN_F, 2'd2, 1'b0);
    drive("fs_cbb1", 1'b1, 1'b1, CBB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_SCAN_F, 2'd1, 1'b0);
    drive("fs_cbb2", 1'b1, 1'b1, CBB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_CORE,   2'd0, 1'b0);

    // Backward scan with an invalid gap: CBB taken, MVR, invalid, CBF
    drive("bs_cbb0", 1'b1, 1'b1, CBB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, S_SCAN_B, 2'd1, 1'b0);
    drive("bs_mvr",  1'b1, 1'b1, MVR, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_SCAN_B, 2'd1, 1'b0);
    drive("bs_gap",  1'b1, 1'b0, CBF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_SCAN_B, 2'd1, 1'b0);
    drive("bs_cbf",  1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_CORE,   2'd0, 1'b0);

    // Nested backward scan
    drive("nb_cbb0", 1'b1, 1'b1, CBB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, S_SCAN_B, 2'd1, 1'b0);
    drive("nb_cbb",  1'b1, 1'b1, CBB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, S_SCAN_B, 2'd2, 1'b0);
    drive("nb_cbf1", 1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_SCAN_B, 2'd1, 1'b0);
    drive("nb_cbf2", 1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_CORE,   2'd0, 1'b0);

    // Reset mid-scan at depth 2, and mid-stall
    drive("rs_cbf0", 1'b1, 1'b1, CBF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, S_SCAN_F, 2'd1, 1'b0);
    drive("rs_cbf",  1'b1, 1'b1, CBF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, S_SCAN_F, 2'd2, 1'b0);
    drive("rs_scan", 1'b0, 1'b1, CBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_CORE,   2'd0, 1'b0);
    drive("rs_pop",  1'b1, 1'b1, POP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_STALL,  2'd0, 1'b0);
    drive("rs_stl",  1'b0, 1'b0, INC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_CORE,   2'd0, 1'b0);
    drive("rs_inc",  1'b1, 1'b1, INC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_CORE,   2'd0, 1'b0);

    // Overflow at depth 3 with DEPTH_W=2, then HALT until reset
    drive("ov_cbf0", 1'b1, 1'b1, CBF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, S_SCAN_F, 2'd1, 1'b0);
    drive("ov_cbf1", 1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_SCAN_F, 2'd2, 1'b0);
    drive("ov_cbf2", 1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_SCAN_F, 2'd3, 1'b0);
    drive("ov_cbf3", 1'b1, 1'b1, CBF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, S_HALT,   2'd3, 1'b1);
    drive("halt_cbb", 1'b1, 1'b1, CBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_HALT,  2'd3, 1'b1);
    drive("halt_pop", 1'b1, 1'b1, POP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_HALT,  2'd3, 1'b1);
    drive("halt_inc", 1'b1, 1'b1, INC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_HALT,  2'd3, 1'b1);
    drive("halt_rst", 1'b0, 1'b1, CBF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_CORE,  2'd0, 1'b0);
    drive("post_inc", 1'b1, 1'b1, INC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_CORE,  2'd0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
